// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Brings the on-chip PLL out of reset, waits for it to lock (with a
//   timeout and a bounded number of retries), and holds the downstream
//   system in reset until lock has been stable for a full window. It then
//   watches for loss of lock, counts those events, and re-sequences the PLL.
//
// Ports
//   clk_i        reference clock (the crystal that also feeds the PLL)
//   rst_n_i      asynchronous active-low reset
//   pll_lock_i   PLL lock indicator, asynchronous to clk_i
//   restart_i    single-cycle request for a full re-sequence
//   pll_reset_o  active-high PLL reset
//   sys_rst_n_o  active-low system reset, released only in RUN
//   locked_o     high only in RUN
//   fail_o       high only in FAIL
//   retry_cnt_o  lock timeouts since the last RUN entry or restart
//   loss_cnt_o   lock-loss events seen in RUN, saturating at 255
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 32,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       pll_lock_i,
    input  logic       restart_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    // One shared timer serves every timed state, so it is sized for the
    // longest interval; it only ever counts up to that interval minus one.
    localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int TW     = (TMAX > 2) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    // Two-flop synchronizer for the asynchronous lock indicator.
    logic lock_meta_reg;
    logic lock_s_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lock_meta_reg <= 1'b0;
            lock_s_reg    <= 1'b0;
        end else begin
            lock_meta_reg <= pll_lock_i;
            lock_s_reg    <= lock_meta_reg;
        end
    end

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [7:0]    retry_reg, retry_next;
    logic [7:0]    loss_reg,  loss_next;
    logic [7:0]    retry_inc;

    logic pll_reset_reg;
    logic sys_rst_n_reg;
    logic locked_reg;
    logic fail_reg;

    assign retry_inc = retry_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;

        case (state_reg)
            ST_RESET: begin
                if (restart_i) begin
                    timer_next = '0;
                    retry_next = 8'd0;
                end else if (timer_reg == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                if (restart_i) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                    retry_next = 8'd0;
                end else if (lock_s_reg) begin
                    state_next = ST_STABLE;
                    timer_next = '0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    timer_next = '0;
                    state_next = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_STABLE: begin
                if (restart_i) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                    retry_next = 8'd0;
                end else if (!lock_s_reg) begin
                    // A dropout restarts the stability window from scratch;
                    // it is not a timeout, so retries are left alone.
                    state_next = ST_WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = ST_RUN;
                    timer_next = '0;
                    retry_next = 8'd0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            ST_RUN: begin
                // Lock loss wins over a coincident restart so the event is
                // never lost from the count.
                if (!lock_s_reg) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                    loss_next  = (loss_reg == 8'hFF) ? 8'hFF : loss_reg + 8'd1;
                end else if (restart_i) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                end
            end

            ST_FAIL: begin
                if (restart_i) begin
                    state_next = ST_RESET;
                    timer_next = '0;
                    retry_next = 8'd0;
                end
            end

            default: begin
                state_next = ST_RESET;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are registered alongside the state and decoded from the
    // state being entered, so they track the state with no extra lag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_RESET;
            timer_reg     <= '0;
            retry_reg     <= 8'd0;
            loss_reg      <= 8'd0;
            pll_reset_reg <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            locked_reg    <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            pll_reset_reg <= (state_next == ST_RESET) || (state_next == ST_FAIL);
            sys_rst_n_reg <= (state_next == ST_RUN);
            locked_reg    <= (state_next == ST_RUN);
            fail_reg      <= (state_next == ST_FAIL);
        end
    end

    assign pll_reset_o = pll_reset_reg;
    assign sys_rst_n_o = sys_rst_n_reg;
    assign locked_o    = locked_reg;
    assign fail_o      = fail_reg;
    assign retry_cnt_o = retry_reg;
    assign loss_cnt_o  = loss_reg;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus a randomized
// phase, every cycle compared against a behavioural model of the sequencer.
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int TO = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       locked;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYCLES(SC),
        .MAX_RETRY    (MR)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pll_lock_i (pll_lock),
        .restart_i  (restart),
        .pll_reset_o(pll_reset),
        .sys_rst_n_o(sys_rst_n),
        .locked_o   (locked),
        .fail_o     (fail),
        .retry_cnt_o(retry_cnt),
        .loss_cnt_o (loss_cnt)
    );

    // ---------------- behavioural reference model ----------------
    // Phase names; each phase tracks how many edges it has lasted so far.
    localparam int M_RESET  = 0;
    localparam int M_WAIT   = 1;
    localparam int M_STABLE = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAIL   = 4;

    int m_phase;
    int m_elapsed;
    int m_retries;
    int m_losses;
    bit m_lockq[$];   // lock samples from the last two edges, oldest first

    function automatic void model_reset();
        m_phase   = M_RESET;
        m_elapsed = 0;
        m_retries = 0;
        m_losses  = 0;
        m_lockq   = '{1'b0, 1'b0};
    endfunction

    function automatic void enter(int p);
        m_phase   = p;
        m_elapsed = 0;
        if (p == M_RUN) m_retries = 0;
    endfunction

    function automatic void model_edge(bit lk, bit rq);
        bit seen;
        seen = m_lockq[0];          // what the FSM sees: lock from two edges ago
        void'(m_lockq.pop_front());
        m_lockq.push_back(lk);
        if (m_phase == M_RUN) begin
            if (!seen) begin
                m_losses = (m_losses < 255) ? m_losses + 1 : 255;
                enter(M_RESET);
            end else if (rq) begin
                enter(M_RESET);
            end
        end else if (rq) begin
            m_retries = 0;
            enter(M_RESET);
        end else begin
            case (m_phase)
                M_RESET: begin
                    m_elapsed++;
                    if (m_elapsed == RC) enter(M_WAIT);
                end
                M_WAIT: begin
                    if (seen) enter(M_STABLE);
                    else begin
                        m_elapsed++;
                        if (m_elapsed == TO) begin
                            m_retries++;
                            enter((m_retries == MR) ? M_FAIL : M_RESET);
                        end
                    end
                end
                M_STABLE: begin
                    if (!seen) enter(M_WAIT);
                    else begin
                        m_elapsed++;
                        if (m_elapsed == SC) enter(M_RUN);
                    end
                end
                default: ;
            endcase
        end
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pll_reset", pll_reset, (m_phase == M_RESET || m_phase == M_FAIL));
        chk("sys_rst_n", sys_rst_n, (m_phase == M_RUN));
        chk("locked", locked, (m_phase == M_RUN));
        chk("fail", fail, (m_phase == M_FAIL));
        chk("retry_cnt", retry_cnt, m_retries);
        chk("loss_cnt", loss_cnt, m_losses);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(pll_lock, restart);
        #1;
        check_all();
    endtask

    int n;

    initial begin
        model_reset();
        tick();
        tick();
        $display("reset: pll_reset=%0b sys_rst_n=%0b", pll_reset, sys_rst_n);

        // 1. nominal bring-up
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            n++;
            if (pll_reset == 1'b0) break;
        end
        chk("pll_reset_edges", n, RC);
        for (int i = 0; i < 4; i++) tick();
        pll_lock = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (sys_rst_n == 1'b1) break;
        end
        chk("release_in_window", (n >= 2 + SC) && (n <= 3 + SC), 1);
        chk("bringup_locked", locked, 1);
        chk("bringup_retry", retry_cnt, 0);
        $display("bringup: release after %0d cycles", n);

        // 2. lock glitch during STABLE
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 40 && !(m_phase == M_STABLE && m_elapsed == 5); i++) tick();
        chk("glitch_reach_stable5", m_phase * 100 + m_elapsed, M_STABLE * 100 + 5);
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        n = 1;
        for (int i = 0; i < 30 && sys_rst_n !== 1'b1; i++) begin
            tick();
            n++;
        end
        chk("glitch_fresh_window", n, 12);
        $display("glitch: release %0d cycles after dropout", n);

        // 3. timeout then FAIL (restart from RUN leaves loss count alone)
        restart = 1'b1;
        pll_lock = 1'b0;
        tick();
        restart = 1'b0;
        n = 0;
        for (int i = 0; i < 100 && fail !== 1'b1; i++) begin
            tick();
            n++;
        end
        chk("fail_latency", n, 2 * (RC + TO));
        chk("fail_flag", fail, 1);
        chk("fail_retry", retry_cnt, MR);
        chk("fail_pll_reset", pll_reset, 1);
        chk("fail_sys_rst", sys_rst_n, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("fail_sticky", fail, 1);
        $display("timeout: fail after %0d cycles retry=%0d", n, retry_cnt);

        // 4. recovery from FAIL
        restart = 1'b1;
        pll_lock = 1'b1;
        tick();
        restart = 1'b0;
        chk("recover_fail_drop", fail, 0);
        chk("recover_retry", retry_cnt, 0);
        for (int i = 0; i < 60 && locked !== 1'b1; i++) tick();
        chk("recover_locked", locked, 1);
        $display("recovery: locked=%0b", locked);

        // 5. lock loss in RUN
        pll_lock = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n++;
            if (sys_rst_n == 1'b0) break;
        end
        chk("loss_latency", n, 3);
        chk("loss_cnt_1", loss_cnt, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (pll_reset == 1'b0) break;
        end
        chk("loss_reset_pulse", n, RC);
        pll_lock = 1'b1;
        for (int i = 0; i < 60 && locked !== 1'b1; i++) tick();
        chk("loss_relock", locked, 1);
        $display("loss: loss_cnt=%0d", loss_cnt);

        // 6. restart coincident with lock_s falling
        pll_lock = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("simul_loss_cnt", loss_cnt, 2);
        chk("simul_sys_rst", sys_rst_n, 0);
        pll_lock = 1'b1;
        for (int i = 0; i < 60 && locked !== 1'b1; i++) tick();
        chk("simul_relock", locked, 1);
        $display("simultaneous: loss_cnt=%0d", loss_cnt);

        // 5b. saturation of the loss counter
        for (int k = 0; k < 256; k++) begin
            pll_lock = 1'b0;
            for (int i = 0; i < 10 && locked !== 1'b0; i++) tick();
            pll_lock = 1'b1;
            for (int i = 0; i < 60 && locked !== 1'b1; i++) tick();
        end
        chk("loss_saturated", loss_cnt, 255);
        chk("sat_locked", locked, 1);
        $display("saturation: loss_cnt=%0d", loss_cnt);

        // randomized lock behaviour and restarts
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 23) == 0) pll_lock = ~pll_lock;
            restart = ($urandom_range(0, 59) == 0);
            tick();
        end
        restart = 1'b0;
        $display("random: phase=%0d retry=%0d loss=%0d", m_phase, m_retries, m_losses);

        // 6b. asynchronous reset during WAIT_LOCK
        pll_lock = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 10 && m_phase != M_WAIT; i++) tick();
        chk("wait_reached", m_phase, M_WAIT);
        chk("loss_before_rst", loss_cnt, m_losses);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_loss_clear", loss_cnt, 0);
        chk("async_pll_reset", pll_reset, 1);
        tick();
        tick();
        rst_n = 1'b1;
        pll_lock = 1'b1;
        for (int i = 0; i < 60 && locked !== 1'b1; i++) tick();
        chk("post_rst_locked", locked, 1);
        $display("async reset: loss_cnt=%0d locked=%0b", loss_cnt, locked);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
